usb_boot_sequencer: RTL and testbench
=====================================

Name: usb_boot_sequencer

Overview:
Reset and warm-boot controller for the USB bootloader top level, sitting beside usb_fs_pe and the endpoint blocks.
- Downstream of the board reset: generates the stretched synchronous active-high usb_reset consumed by usb_fs_pe, usb_serial_ctrl_ep and usb_spi_bridge_ep.
- Downstream of the USB engine: consumes sof_valid/frame_index and the bridge endpoint's boot request.
- Upstream of SB_WARMBOOT: drives BOOT/S1/S0 with host-presence timeout and a deferred boot, so the final host transaction is ACKed before reconfiguration.

Parameters:
TIMEOUT_CYCLES, 48000000, clocks with no SOF before a timeout boot.
RESET_CYCLES, 16, clocks usb_reset stays high after synchronised reset_n release.
PRESENT_SOFS, 4, consecutive in-sequence SOFs required to declare host present.
BOOT_DELAY_SOFS, 2, SOFs to wait in BOOT_PENDING before booting.
BOOT_DELAY_CYCLES, 96000, fallback clock limit in BOOT_PENDING (2 ms at 48 MHz).
DEFAULT_IMAGE, 2'b01, {S1,S0} used for timeout boots and at reset.

Ports:
clk  in  1  48 MHz system clock.
reset_n  in  1  asynchronous active-low reset.
sof_valid  in  1  single-cycle SOF strobe from usb_fs_pe.
frame_index  in  11  frame number, valid with sof_valid.
boot_req  in  1  boot request from the bridge endpoint; level or pulse, sampled per cycle.
boot_image  in  2  {S1,S0} requested with boot_req.
usb_reset  out  1  synchronous active-high reset to the USB engine and endpoints.
host_present  out  1  host detected and SOFs in sequence.
boot  out  1  to SB_WARMBOOT.BOOT.
boot_s1  out  1  to SB_WARMBOOT.S1.
boot_s0  out  1  to SB_WARMBOOT.S0.
state  out  3  debug encoding of the current state.

Behaviour:
Reset (reset_n low, asynchronous):
- usb_reset=1, host_present=0, boot=0, {boot_s1,boot_s0}=DEFAULT_IMAGE, state=RESET_HOLD.
- All counters = 0.
- Reset mid-operation (including in BOOT_PENDING) abandons the pending boot; boot is never asserted.

Release:
- reset_n goes through a 2-flop synchroniser. Asynchronous assertion, synchronous deassertion.

State encodings: RESET_HOLD=0, WAIT_HOST=1, HOST_PRESENT=2, BOOT_PENDING=3, BOOT=4. All outputs are registered and update the cycle after a transition.

RESET_HOLD:
- Count RESET_CYCLES clocks after synchronised release.
- Then usb_reset<=0 and go to WAIT_HOST.
- sof_valid and boot_req are ignored.

Presence timer:
- Width clog2(TIMEOUT_CYCLES+1). Runs in WAIT_HOST and HOST_PRESENT only.
- Cleared to 0 on any cycle with sof_valid; otherwise increments by 1.
- Timeout fires when timer==TIMEOUT_CYCLES-1 and sof_valid=0. The timer never wraps.
- Timeout: go to BOOT with image DEFAULT_IMAGE, host_present<=0.
- sof_valid on the timeout cycle: SOF wins, no timeout.

SOF sequence counter (saturating at PRESENT_SOFS):
- On sof_valid: if count>0 and frame_index == (last_index+1) mod 2048, count+1; otherwise count=1.
- last_index<=frame_index on every SOF. Wrap from 2047 to 0 counts as in sequence.
- WAIT_HOST: when count reaches PRESENT_SOFS, set host_present<=1 and go to HOST_PRESENT.
- HOST_PRESENT: an out-of-sequence SOF sets count=1 and host_present<=0, returning to WAIT_HOST.

boot_req (sampled in WAIT_HOST or HOST_PRESENT):
- Latch boot_image into {boot_s1,boot_s0}, clear the delay counters, go to BOOT_PENDING.
- Same cycle as a timeout: boot_req wins and uses boot_image.
- Ignored in RESET_HOLD, BOOT_PENDING and BOOT; the latched image does not change.

BOOT_PENDING:
- Count SOFs and cycles; the timer is frozen.
- Go to BOOT when the SOF count reaches BOOT_DELAY_SOFS or the cycle count reaches BOOT_DELAY_CYCLES-1, whichever comes first.
- host_present holds its value.

BOOT:
- boot=1, image held, usb_reset=0.
- Terminal until reset_n.

Test Plan:
Bench parameters: TIMEOUT_CYCLES=1000, RESET_CYCLES=16, PRESENT_SOFS=4, BOOT_DELAY_SOFS=2, BOOT_DELAY_CYCLES=200.

1. reset_n low 5 cycles then high -> usb_reset=1 through 2 sync + 16 cycles, then 0, state=1; all other outputs at reset values.
2. No SOF after release -> boot=1 exactly 1000 cycles after entering WAIT_HOST, {s1,s0}=01, host_present=0; a single SOF at cycle 999 instead restarts the count and gives no boot.
3. SOFs with frame_index 2046,2047,0,1 every 100 cycles -> host_present=1 after the 4th SOF; then frame 5 -> host_present=0, state=1.
4. In HOST_PRESENT, boot_req pulse with boot_image=2'b10, then SOFs 50 and 100 cycles later -> boot=1 one cycle after the 2nd SOF, {s1,s0}=10.
5. boot_req with no further SOFs -> boot=1 200 cycles later; a second boot_req with image 11 during pending leaves image 10.
6. boot_req then reset_n low 100 cycles later -> boot stays 0, usb_reset=1; a boot_req coincident with timeout -> image from boot_image.

Source files
------------

// File: rtl/usb_boot_sequencer_if.sv
// usb_boot_sequencer_if: USB engine strobes, boot request and warm-boot/reset outputs of the boot sequencer.
interface usb_boot_sequencer_if;
    logic        sof_valid;
    logic [10:0] frame_index;
    logic        boot_req;
    logic [1:0]  boot_image;
    logic        usb_reset;
    logic        host_present;
    logic        boot;
    logic        boot_s1;
    logic        boot_s0;
    logic [2:0]  state;
    modport master (
        output sof_valid, frame_index, boot_req, boot_image,
        input  usb_reset, host_present, boot, boot_s1, boot_s0, state
    );
    modport slave (
        input  sof_valid, frame_index, boot_req, boot_image,
        output usb_reset, host_present, boot, boot_s1, boot_s0, state
    );
endinterface

// File: rtl/usb_boot_sequencer.sv
// usb_boot_sequencer: stretched USB reset, host-presence tracking and deferred SB_WARMBOOT control.
module usb_boot_sequencer #(
    parameter int         TIMEOUT_CYCLES    = 48000000,
    parameter int         RESET_CYCLES      = 16,
    parameter int         PRESENT_SOFS      = 4,
    parameter int         BOOT_DELAY_SOFS   = 2,
    parameter int         BOOT_DELAY_CYCLES = 96000,
    parameter logic [1:0] DEFAULT_IMAGE     = 2'b01
) (
    input logic           clk,
    input logic           reset_n,
    usb_boot_sequencer_if.slave bus
);
    localparam logic [2:0] RESET_HOLD   = 3'd0;
    localparam logic [2:0] WAIT_HOST    = 3'd1;
    localparam logic [2:0] HOST_PRESENT = 3'd2;
    localparam logic [2:0] BOOT_PENDING = 3'd3;
    localparam logic [2:0] BOOT         = 3'd4;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW  = $clog2(RESET_CYCLES + 1);
    localparam int SW  = $clog2(PRESENT_SOFS + 1);
    localparam int DSW = $clog2(BOOT_DELAY_SOFS + 1);
    localparam int DCW = $clog2(BOOT_DELAY_CYCLES + 1);

    logic [1:0]     sync;
    logic [2:0]     state_q, state_d;
    logic [HW-1:0]  hold_cnt;
    logic [TW-1:0]  timer;
    logic [SW-1:0]  seq_cnt, seq_next;
    logic [10:0]    last_index;
    logic [DSW-1:0] dly_sofs, dly_sofs_next;
    logic [DCW-1:0] dly_cycles;
    logic           usb_reset_q, host_q, boot_q;
    logic [1:0]     image_q;
    logic           released, active, in_seq, present, timeout, hold_done, dly_done;

    assign released      = sync[1];
    assign active        = state_q == WAIT_HOST || state_q == HOST_PRESENT;
    assign in_seq        = seq_cnt != '0 && bus.frame_index == last_index + 11'd1;
    assign seq_next      = in_seq ? (seq_cnt == SW'(PRESENT_SOFS) ? seq_cnt : seq_cnt + SW'(1)) : SW'(1);
    assign present       = seq_next == SW'(PRESENT_SOFS);
    // A SOF on the final cycle clears the timer, so it pre-empts the timeout
    assign timeout       = timer == TW'(TIMEOUT_CYCLES - 1) && !bus.sof_valid;
    assign hold_done     = released && hold_cnt == HW'(RESET_CYCLES - 1);
    assign dly_sofs_next = dly_sofs + DSW'(bus.sof_valid);
    assign dly_done      = dly_sofs_next == DSW'(BOOT_DELAY_SOFS) || dly_cycles == DCW'(BOOT_DELAY_CYCLES - 1);

    always_comb begin
        state_d = state_q == RESET_HOLD   ? (hold_done ? WAIT_HOST : RESET_HOLD)
                : state_q == BOOT_PENDING ? (dly_done ? BOOT : BOOT_PENDING)
                : !active                 ? state_q
                : bus.boot_req            ? BOOT_PENDING
                : timeout                 ? BOOT
                : !bus.sof_valid          ? state_q
                : state_q == WAIT_HOST    ? (present ? HOST_PRESENT : WAIT_HOST)
                : in_seq                  ? HOST_PRESENT : WAIT_HOST;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync        <= '0;
            state_q     <= RESET_HOLD;
            hold_cnt    <= '0;
            timer       <= '0;
            seq_cnt     <= '0;
            last_index  <= '0;
            dly_sofs    <= '0;
            dly_cycles  <= '0;
            usb_reset_q <= 1'b1;
            host_q      <= 1'b0;
            boot_q      <= 1'b0;
            image_q     <= DEFAULT_IMAGE;
        end else begin
            sync        <= {sync[0], 1'b1};
            state_q     <= state_d;
            usb_reset_q <= state_d == RESET_HOLD;
            boot_q      <= state_d == BOOT;
            if (state_q == RESET_HOLD && released)
                hold_cnt <= hold_cnt + HW'(1);
            if (active)
                timer <= bus.sof_valid ? '0 : timer + TW'(1);
            if (active && bus.sof_valid) begin
                seq_cnt    <= seq_next;
                last_index <= bus.frame_index;
            end
            // Delay counters sit at zero everywhere except BOOT_PENDING
            dly_sofs   <= state_q == BOOT_PENDING ? dly_sofs_next : '0;
            dly_cycles <= state_q == BOOT_PENDING ? dly_cycles + DCW'(1) : '0;
            if (active)
                host_q <= state_d == HOST_PRESENT || (state_d == BOOT_PENDING && host_q);
            if (active && bus.boot_req)
                image_q <= bus.boot_image;
            else if (active && timeout)
                image_q <= DEFAULT_IMAGE;
        end
    end

    assign bus.usb_reset    = usb_reset_q;
    assign bus.host_present = host_q;
    assign bus.boot         = boot_q;
    assign bus.boot_s1      = image_q[1];
    assign bus.boot_s0      = image_q[0];
    assign bus.state        = state_q;
endmodule

// File: tb/tb_usb_boot_sequencer.sv
// tb_usb_boot_sequencer: directed scenarios for reset stretch, timeout, presence and deferred boot.
module tb_usb_boot_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   cmp = 0;
    int   bad = 0;

    usb_boot_sequencer_if bus();

    usb_boot_sequencer #(
        .TIMEOUT_CYCLES(1000), .RESET_CYCLES(16), .PRESENT_SOFS(4),
        .BOOT_DELAY_SOFS(2), .BOOT_DELAY_CYCLES(200), .DEFAULT_IMAGE(2'b01)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.sof_valid = 1'b0; bus.frame_index = '0; bus.boot_req = 1'b0; bus.boot_image = 2'b00;
    endtask

    task automatic boot_up;
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (18) step();
    endtask

    task automatic send_sof(input logic [10:0] f);
        bus.sof_valid = 1'b1; bus.frame_index = f;
        step();
        bus.sof_valid = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        #3 reset_n = 1'b0;
        repeat (5) step();
        cmp++; if (bus.usb_reset !== 1'b1) begin bad++; $display("FAIL rst_usb_reset got %b want 1", bus.usb_reset); end
        cmp++; if (bus.host_present !== 1'b0) begin bad++; $display("FAIL rst_host got %b want 0", bus.host_present); end
        cmp++; if (bus.boot !== 1'b0) begin bad++; $display("FAIL rst_boot got %b want 0", bus.boot); end
        cmp++; if ({bus.boot_s1, bus.boot_s0} !== 2'b01) begin bad++; $display("FAIL rst_image got %b want 01", {bus.boot_s1, bus.boot_s0}); end
        cmp++; if (bus.state !== 3'd0) begin bad++; $display("FAIL rst_state got %0d want 0", bus.state); end
        reset_n = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step();
            cmp++; if (bus.usb_reset !== (i < 18)) begin bad++; $display("FAIL stretch_%0d got %b want %b", i, bus.usb_reset, i < 18); end
        end
        cmp++; if (bus.state !== 3'd1) begin bad++; $display("FAIL release_state got %0d want 1", bus.state); end
        cmp++; if (bus.boot !== 1'b0 || bus.host_present !== 1'b0) begin bad++; $display("FAIL release_outs got boot=%b host=%b want 0 0", bus.boot, bus.host_present); end
    endtask

    task automatic test_timeout;
        boot_up();
        repeat (999) step();
        cmp++; if (bus.boot !== 1'b0 || bus.state !== 3'd1) begin bad++; $display("FAIL pre_timeout got boot=%b state=%0d want 0 1", bus.boot, bus.state); end
        step();
        cmp++; if (bus.boot !== 1'b1 || bus.state !== 3'd4) begin bad++; $display("FAIL timeout_boot got boot=%b state=%0d want 1 4", bus.boot, bus.state); end
        cmp++; if ({bus.boot_s1, bus.boot_s0} !== 2'b01 || bus.host_present !== 1'b0) begin bad++; $display("FAIL timeout_image got %b host=%b want 01 0", {bus.boot_s1, bus.boot_s0}, bus.host_present); end
        boot_up();
        repeat (999) step();
        send_sof(11'd0);
        cmp++; if (bus.boot !== 1'b0 || bus.state !== 3'd1) begin bad++; $display("FAIL sof_saves got boot=%b state=%0d want 0 1", bus.boot, bus.state); end
        repeat (999) step();
        cmp++; if (bus.boot !== 1'b0) begin bad++; $display("FAIL restart_early got %b want 0", bus.boot); end
        step();
        cmp++; if (bus.boot !== 1'b1) begin bad++; $display("FAIL restart_timeout got %b want 1", bus.boot); end
    endtask

    task automatic test_presence;
        boot_up();
        send_sof(11'd2046); repeat (99) step();
        send_sof(11'd2047); repeat (99) step();
        send_sof(11'd0);
        cmp++; if (bus.host_present !== 1'b0) begin bad++; $display("FAIL three_sofs got %b want 0", bus.host_present); end
        repeat (99) step();
        send_sof(11'd1);
        cmp++; if (bus.host_present !== 1'b1 || bus.state !== 3'd2) begin bad++; $display("FAIL present got host=%b state=%0d want 1 2", bus.host_present, bus.state); end
        repeat (99) step();
        send_sof(11'd5);
        cmp++; if (bus.host_present !== 1'b0 || bus.state !== 3'd1) begin bad++; $display("FAIL lost got host=%b state=%0d want 0 1", bus.host_present, bus.state); end
    endtask

    task automatic test_boot_sof;
        boot_up();
        for (int f = 10; f < 14; f++) begin
            send_sof(11'(f));
            repeat (9) step();
        end
        cmp++; if (bus.state !== 3'd2) begin bad++; $display("FAIL pre_req_state got %0d want 2", bus.state); end
        bus.boot_req = 1'b1; bus.boot_image = 2'b10;
        step();
        bus.boot_req = 1'b0;
        cmp++; if (bus.state !== 3'd3 || bus.host_present !== 1'b1) begin bad++; $display("FAIL pending got state=%0d host=%b want 3 1", bus.state, bus.host_present); end
        repeat (49) step();
        send_sof(11'd14);
        repeat (49) step();
        cmp++; if (bus.boot !== 1'b0) begin bad++; $display("FAIL one_sof got %b want 0", bus.boot); end
        send_sof(11'd15);
        cmp++; if (bus.boot !== 1'b1 || bus.state !== 3'd4) begin bad++; $display("FAIL sof_boot got boot=%b state=%0d want 1 4", bus.boot, bus.state); end
        cmp++; if ({bus.boot_s1, bus.boot_s0} !== 2'b10) begin bad++; $display("FAIL sof_image got %b want 10", {bus.boot_s1, bus.boot_s0}); end
    endtask

    task automatic test_boot_cycles;
        boot_up();
        bus.boot_req = 1'b1; bus.boot_image = 2'b10;
        step();
        bus.boot_image = 2'b11;
        step();
        bus.boot_req = 1'b0;
        repeat (198) step();
        cmp++; if (bus.boot !== 1'b0 || bus.state !== 3'd3) begin bad++; $display("FAIL cyc_pre got boot=%b state=%0d want 0 3", bus.boot, bus.state); end
        step();
        cmp++; if (bus.boot !== 1'b1) begin bad++; $display("FAIL cyc_boot got %b want 1", bus.boot); end
        cmp++; if ({bus.boot_s1, bus.boot_s0} !== 2'b10) begin bad++; $display("FAIL cyc_image got %b want 10", {bus.boot_s1, bus.boot_s0}); end
    endtask

    task automatic test_back_to_back;
        boot_up();
        bus.boot_req = 1'b1; bus.boot_image = 2'b11;
        step();
        bus.boot_req = 1'b0;
        repeat (99) step();
        reset_n = 1'b0;
        #1;
        cmp++; if (bus.usb_reset !== 1'b1 || bus.boot !== 1'b0 || bus.state !== 3'd0) begin bad++; $display("FAIL abort got rst=%b boot=%b state=%0d want 1 0 0", bus.usb_reset, bus.boot, bus.state); end
        repeat (150) step();
        cmp++; if (bus.boot !== 1'b0 || {bus.boot_s1, bus.boot_s0} !== 2'b01) begin bad++; $display("FAIL abort_hold got boot=%b img=%b want 0 01", bus.boot, {bus.boot_s1, bus.boot_s0}); end
        boot_up();
        repeat (999) step();
        bus.boot_req = 1'b1; bus.boot_image = 2'b11;
        step();
        bus.boot_req = 1'b0;
        cmp++; if (bus.state !== 3'd3 || bus.boot !== 1'b0) begin bad++; $display("FAIL coincide got state=%0d boot=%b want 3 0", bus.state, bus.boot); end
        cmp++; if ({bus.boot_s1, bus.boot_s0} !== 2'b11) begin bad++; $display("FAIL coincide_image got %b want 11", {bus.boot_s1, bus.boot_s0}); end
        repeat (200) step();
        cmp++; if (bus.boot !== 1'b1 || {bus.boot_s1, bus.boot_s0} !== 2'b11) begin bad++; $display("FAIL coincide_boot got boot=%b img=%b want 1 11", bus.boot, {bus.boot_s1, bus.boot_s0}); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_presence();
        test_boot_sof();
        test_boot_cycles();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
